// File: rtl/spi_mstr_param.sv
// rtl/spi_mstr_param.sv - parametrised full-duplex SPI master with runtime CPOL/CPHA, length and slave select
// SCLK is a flop that only moves at divider terminal counts, so it never glitches.
module spi_mstr_param #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 5,
    parameter int NUM_SS = 1,
    localparam int LEN_W = (DATA_W > 1) ? $clog2(DATA_W) : 1,
    localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [DATA_W-1:0] cmd,
    input  logic [LEN_W-1:0]  len,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic [NUM_SS-1:0] SS_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {IDLE, FRNT_PRCH, MAIN, BCK_PRCH} state_t;

    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'((1 << (DIV_W - 1)) - 1);
    localparam logic [DIV_W-1:0] PER_LAST  = '1;
    localparam logic [LEN_W-1:0] LEN_TOP   = LEN_W'(DATA_W - 1);

    state_t              r_state;
    state_t              w_nxt;
    logic [DIV_W-1:0]    r_div;
    logic [LEN_W-1:0]    r_bit;
    logic [LEN_W-1:0]    r_len;
    logic [DATA_W-1:0]   r_shft;
    logic [NUM_SS-1:0]   r_ss_n;
    logic [NUM_SS-1:0]   w_ss_dec;
    logic                r_miso;
    logic                r_sclk;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_done;
    logic                w_accept;
    logic                w_lead1;
    logic                w_lead_n;
    logic                w_trail;
    logic                w_end;
    logic                w_sample;
    logic                w_shift;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:      if (wrt) w_nxt = FRNT_PRCH;
            FRNT_PRCH: if (r_div == HALF_LAST) w_nxt = MAIN;
            MAIN:      if (r_div == PER_LAST && r_bit == r_len) w_nxt = BCK_PRCH;
            BCK_PRCH:  if (r_div == HALF_LAST) w_nxt = IDLE;
            default:   w_nxt = IDLE;
        endcase
    end

    // Leading edge 1 comes from the front porch; later leading edges from MAIN period wraps.
    always_comb begin
        busy     = 1'b1;
        w_accept = 1'b0;
        w_lead1  = 1'b0;
        w_lead_n = 1'b0;
        w_trail  = 1'b0;
        w_end    = 1'b0;
        case (r_state)
            IDLE: begin
                busy     = 1'b0;
                w_accept = wrt;
            end
            FRNT_PRCH: w_lead1 = (r_div == HALF_LAST);
            MAIN: begin
                w_trail  = (r_div == HALF_LAST);
                w_lead_n = (r_div == PER_LAST) && (r_bit != r_len);
            end
            BCK_PRCH:  w_end = (r_div == HALF_LAST);
            default:   busy = 1'b0;
        endcase
        w_sample = r_cpha ? w_trail : (w_lead1 | w_lead_n);
        w_shift  = r_cpha ? (w_lead_n | w_end) : w_trail;
    end

    always_comb begin
        w_ss_dec = '0;
        for (int i = 0; i < NUM_SS; i++) begin
            if (ss_sel == SS_W'(i)) w_ss_dec[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_bit  <= '0;
            r_len  <= '0;
            r_shft <= '0;
            r_ss_n <= '1;
            r_miso <= 1'b0;
            r_sclk <= 1'b1;
            r_cpol <= 1'b1;
            r_cpha <= 1'b1;
            r_done <= 1'b0;
        end else if (w_accept) begin
            r_div  <= '0;
            r_bit  <= '0;
            r_len  <= len;
            r_shft <= cmd << (LEN_TOP - len);
            r_ss_n <= ~w_ss_dec;
            r_sclk <= cpol;
            r_cpol <= cpol;
            r_cpha <= cpha;
            r_done <= 1'b0;
        end else begin
            if (r_state == IDLE || w_nxt != r_state) r_div <= '0;
            else                                     r_div <= r_div + 1'b1;
            if (r_state == MAIN && r_div == PER_LAST) r_bit <= r_bit + 1'b1;
            if (w_lead1 || w_lead_n) r_sclk <= ~r_cpol;
            else if (w_trail)        r_sclk <= r_cpol;
            if (w_sample) r_miso <= MISO;
            if (w_shift)  r_shft <= {r_shft[DATA_W-2:0], r_miso};
            if (w_end) begin
                r_ss_n <= '1;
                r_done <= 1'b1;
            end
        end
    end

    assign SCLK    = r_sclk;
    assign MOSI    = r_shft[DATA_W-1];
    assign SS_n    = r_ss_n;
    assign done    = r_done;
    assign rd_data = r_shft;

endmodule

// File: tb/tb_spi_mstr_param.sv
// tb/tb_spi_mstr_param.sv - scoreboard bench for spi_mstr_param with a mode-aware slave model
module tb_spi_mstr_param;

    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrt;
    logic [15:0] cmd;
    logic [3:0]  len;
    logic [1:0]  ss_sel;
    logic        cpol;
    logic        cpha;
    logic        MISO;
    logic        SCLK;
    logic        MOSI;
    logic [2:0]  SS_n;
    logic        busy;
    logic        done;
    logic [15:0] rd_data;

    always #5 clk = ~clk;

    spi_mstr_param #(.DATA_W(16), .DIV_W(3), .NUM_SS(3)) dut (
        .clk(clk), .rst(rst), .wrt(wrt), .cmd(cmd), .len(len), .ss_sel(ss_sel),
        .cpol(cpol), .cpha(cpha), .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI),
        .SS_n(SS_n), .busy(busy), .done(done), .rd_data(rd_data)
    );

    typedef struct {
        logic [15:0] rd;
        logic [15:0] rx;
        int          n;
        logic        pol;
        logic [2:0]  pat;
        int          lo;
        int          cyc;
        logic        mosi0;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_x;
    int          n_tot = 0;
    int          n_bad = 0;

    logic [15:0] s_data = '0;
    int          s_n    = 16;
    logic        s_cpha = 1'b1;
    logic        s_loop = 1'b0;

    int          e      = 0;
    logic [15:0] rx     = '0;
    int          m_cyc  = 0;
    int          m_lo   = 0;
    logic [2:0]  m_and  = '1;
    logic [2:0]  m_or   = '0;
    logic        m_pol0 = 1'b0;
    logic        m_mosi0 = 1'b0;
    logic        busy_q = 1'b0;
    logic        done_q = 1'b0;
    logic        sclk_q = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tot++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Slave drives its next bit from the count of SCLK edges seen so far.
    always_comb begin
        int idx;
        idx = s_cpha ? ((e == 0) ? 0 : (e - 1) / 2) : e / 2;
        if (s_loop)         MISO = MOSI;
        else if (idx < s_n) MISO = s_data[s_n - 1 - idx];
        else                MISO = 1'b0;
    end

    always @(negedge clk) begin
        if (busy && !busy_q) begin
            e = 0; rx = '0; m_cyc = 0; m_lo = 0; m_and = '1; m_or = '0;
            m_pol0 = SCLK; m_mosi0 = MOSI; sclk_q = SCLK;
        end else if (busy && SCLK !== sclk_q) begin
            e++;
            sclk_q = SCLK;
            if ((e % 2 == 1) != s_cpha) rx = {rx[14:0], MOSI};
        end
        if (busy) begin
            m_cyc++;
            if (SS_n != 3'b111) m_lo++;
            m_and &= SS_n;
            m_or  |= SS_n;
        end
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", exp_q.size(), 1);
            end else begin
                m_x = exp_q.pop_front();
                chk("rd_data",    rd_data, m_x.rd);
                chk("slave_rx",   rx, m_x.rx);
                chk("sclk_edges", e, 2 * m_x.n);
                chk("sclk_idle0", m_pol0, m_x.pol);
                chk("sclk_idle1", SCLK, m_x.pol);
                chk("mosi_first", m_mosi0, m_x.mosi0);
                chk("busy_cycles", m_cyc, m_x.cyc);
                chk("ss_low_cycles", m_lo, m_x.lo);
                chk("ss_and", m_and, m_x.pat);
                chk("ss_or",  m_or,  m_x.pat);
            end
        end
        busy_q = busy;
        done_q = done;
    end

    task automatic xfer(input logic [15:0] c, input logic [3:0] l, input logic [1:0] ss,
                        input logic pol, input logic pha, input logic [15:0] sd, input logic lp,
                        input logic [15:0] erd, input logic [15:0] erx, input logic [2:0] pat,
                        input logic push);
        exp_t x;
        x.rd = erd; x.rx = erx; x.n = int'(l) + 1; x.pol = pol; x.pat = pat;
        x.cyc = 2 * H * (int'(l) + 2);
        x.lo = (pat == 3'b111) ? 0 : x.cyc;
        x.mosi0 = c[l];
        if (push) exp_q.push_back(x);
        s_data = sd; s_n = int'(l) + 1; s_cpha = pha; s_loop = lp;
        cmd = c; len = l; ss_sel = ss; cpol = pol; cpha = pha; wrt = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge clk);
        while (done !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done, 1);
    endtask

    initial begin
        int          lead;
        int          t;
        logic        sq;
        logic [1:0]  m;
        rst = 1'b1; wrt = 1'b0; cmd = '0; len = '0; ss_sel = '0; cpol = 1'b0; cpha = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", SS_n, 3'b111);
        chk("rst_sclk", SCLK, 1);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd",   rd_data, 0);
        chk("rst_mosi", MOSI, 0);
        rst = 1'b0;
        @(negedge clk);

        xfer(16'hA5C3, 4'd15, 2'd0, 1'b1, 1'b1, 16'h3C5A, 1'b0, 16'h3C5A, 16'hA5C3, 3'b110, 1'b1);
        wait_done();

        for (int i = 0; i < 4; i++) begin
            m = 2'(i);
            xfer(16'h5A96, 4'd7, 2'd0, m[1], m[0], 16'h0000, 1'b1, 16'h0096, 16'h0096, 3'b110, 1'b1);
            wait_done();
        end

        xfer(16'h000B, 4'd3, 2'd2, 1'b0, 1'b0, 16'h0006, 1'b0, 16'h0006, 16'h000B, 3'b011, 1'b1);
        wait_done();
        xfer(16'h000B, 4'd3, 2'd3, 1'b0, 1'b0, 16'h0006, 1'b0, 16'h0006, 16'h000B, 3'b111, 1'b1);
        wait_done();

        xfer(16'h003C, 4'd7, 2'd1, 1'b0, 1'b1, 16'h00C3, 1'b0, 16'h00C3, 16'h003C, 3'b101, 1'b1);
        repeat (20) @(negedge clk);
        cmd = 16'hFFFF; len = 4'd15; ss_sel = 2'd0; cpol = 1'b1; cpha = 1'b0; wrt = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
        wait_done();

        xfer(16'h0015, 4'd4, 2'd0, 1'b1, 1'b0, 16'h000A, 1'b0, 16'h000A, 16'h0015, 3'b110, 1'b1);
        chk("done_clr_next", done, 0);
        chk("busy_next", busy, 1);
        wait_done();

        xfer(16'hFFFF, 4'd15, 2'd1, 1'b1, 1'b1, 16'h0F0F, 1'b0, 16'h0000, 16'h0000, 3'b101, 1'b0);
        lead = 0; t = 0; sq = SCLK;
        while (lead < 5 && t < 2000) begin
            @(negedge clk);
            t++;
            if (SCLK !== sq) begin
                sq = SCLK;
                if (SCLK == 1'b0) lead++;
            end
        end
        chk("lead_edges_seen", lead, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ss_n", SS_n, 3'b111);
        chk("abort_sclk", SCLK, 1);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd",   rd_data, 0);
        @(negedge clk);

        xfer(16'h1234, 4'd15, 2'd0, 1'b0, 1'b0, 16'hABCD, 1'b0, 16'hABCD, 16'h1234, 3'b110, 1'b1);
        wait_done();

        xfer(16'h8001, 4'd0, 2'd0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0001, 16'h0001, 3'b110, 1'b1);
        wait_done();

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
